// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with prefetch queue and branch redirect
//
// Owns the fetch PC, issues word reads to instruction memory, buffers returned
// words with their PC+1 in a DEPTH-entry FIFO and hands them to decode.
// Optional build macro: FETCH_PERF_CNT_EN adds fetch_cnt / discard_cnt.
//
// Ports:
//   clk, reset             clock, synchronous active-low reset
//   imem_req/addr          word read request and its [31:2] address
//   imem_ack/rdata         memory response for the outstanding request
//   redirect/redirect_pc   flush the queue and re-steer the fetch PC
//   inst_valid/inst/
//   inst_pc_plus4          queue head presented to decode
//   inst_ready             decode accepts the head
//   count                  queue occupancy
//   fetch_cnt/discard_cnt  pushes / dropped responses (FETCH_PERF_CNT_EN only)
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [29:0] RESET_PC = 30'h100000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [29:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [29:0]              redirect_pc,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [29:0]              inst_pc_plus4,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              fetch_cnt,
  output logic [31:0]              discard_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [29:0]     pc, pc_next;
  logic [29:0]     discard_addr;
  logic [31:0]     mem_inst [DEPTH];
  logic [29:0]     mem_pc   [DEPTH];
  logic [AW-1:0]   head, tail;
  logic            push, pop, drop;
  logic [CW-1:0]   count_next;

  // A redirect wins over both a response and a pop in the same cycle.
  assign push       = (state == WAIT) && imem_ack && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;
  assign count_next = redirect ? '0 : (count + CW'(push) - CW'(pop));

  assign imem_req      = (state != IDLE);
  // The abandoned address must stay on the bus until memory answers it.
  assign imem_addr     = (state == DISCARD) ? discard_addr : pc;
  assign inst_valid    = (count != '0);
  assign inst          = inst_valid ? mem_inst[head] : 32'd0;
  assign inst_pc_plus4 = inst_valid ? mem_pc[head]   : 30'd0;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          state_next = WAIT;
        end else if (count_next < CW'(DEPTH)) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_next    = redirect_pc;
          drop       = imem_ack;
          // Without a coinciding ack the old request is still in flight.
          state_next = imem_ack ? WAIT : DISCARD;
        end else if (imem_ack) begin
          pc_next    = pc + 30'd1;
          state_next = (count_next < CW'(DEPTH)) ? WAIT : IDLE;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          drop       = 1'b1;
          state_next = WAIT;
        end
        if (redirect) begin
          pc_next = redirect_pc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      discard_addr <= RESET_PC;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      count <= count_next;
      if (state == WAIT && redirect && !imem_ack) begin
        discard_addr <= pc;
      end
      if (redirect) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_inst[tail] <= imem_rdata;
      mem_pc[tail]   <= pc + 30'd1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      fetch_cnt   <= fetch_cnt + 32'(push);
      discard_cnt <= discard_cnt + 32'(drop);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with a scoreboard queue
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [29:0] RESET_PC = 30'h100000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [29:0] inst_pc_plus4;
  logic        inst_ready;
  logic [2:0]  count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] discard_cnt;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc_plus4(inst_pc_plus4),
    .inst_ready(inst_ready),
    .count(count)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt),
    .discard_cnt(discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory never answers while the queue is full, so no push can hit a full queue.
  assert property (@(posedge clk) disable iff (!reset)
    !(imem_req && imem_ack && count == 3'(DEPTH)));

  int          total = 0;
  int          bad   = 0;
  logic [61:0] sb [$];
  logic [29:0] pc_e;
  int          n;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'hC3A5_0F00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus. keep marks an ack whose data must reach decode.
  task automatic drive(input logic ack, input logic ready, input logic redir,
                       input logic [29:0] rpc, input logic keep);
    logic [61:0] e;
    imem_ack    = ack;
    imem_rdata  = ack ? mem_word(imem_addr) : 32'd0;
    inst_ready  = ready;
    redirect    = redir;
    redirect_pc = rpc;
    if (ack && keep) begin
      chk("fetch_addr", 64'(imem_addr), 64'(pc_e));
      sb.push_back({mem_word(pc_e), pc_e + 30'd1});
      pc_e = pc_e + 30'd1;
    end
    if (redir) begin
      sb.delete();
      pc_e = rpc;
    end else if (inst_valid && ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("head", 64'({inst, inst_pc_plus4}), 64'(e));
      end
    end
    tick();
  endtask

  initial begin
    reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    redirect = 1'b0; redirect_pc = 30'd0; inst_ready = 1'b0;
    pc_e = RESET_PC;
    tick(); tick();

    // reset state
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'(RESET_PC));
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_pc4", 64'(inst_pc_plus4), 64'd0);

    // first request one cycle after reset release
    reset = 1'b1;
    tick();
    chk("first_req", 64'(imem_req), 64'd1);
    chk("first_addr", 64'(imem_addr), 64'(RESET_PC));

    // zero-wait memory, decode always ready: one instruction per cycle
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        chk("stream_valid", 64'(inst_valid), 64'd1);
        chk("stream_count", 64'(count), 64'd1);
      end
      drive(1'b1, 1'b1, 1'b0, 30'd0, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b0, 30'd0, 1'b0);
    chk("drain_count", 64'(count), 64'd0);

    // decode stalled: exactly DEPTH pushes, then fetch idles
    n = 0;
    while (imem_req && n < 10) begin
      drive(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
      n++;
    end
    chk("fill_acks", 64'(n), 64'(DEPTH));
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_req", 64'(imem_req), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 30'd0, 1'b0);
    chk("full_hold_req", 64'(imem_req), 64'd0);
    drive(1'b0, 1'b1, 1'b0, 30'd0, 1'b0);
    chk("pop1_count", 64'(count), 64'd3);
    chk("pop1_req", 64'(imem_req), 64'd1);
    chk("pop1_addr", 64'(imem_addr), 64'h10000A);
    drive(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    chk("refill_count", 64'(count), 64'(DEPTH));
    chk("refill_req", 64'(imem_req), 64'd0);
    repeat (DEPTH) drive(1'b0, 1'b1, 1'b0, 30'd0, 1'b0);
    chk("empty_count", 64'(count), 64'd0);
    chk("empty_addr", 64'(imem_addr), 64'h10000B);

    // slow memory, redirect while the request is in flight
    drive(1'b0, 1'b0, 1'b0, 30'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 30'h200, 1'b0);
    chk("disc_addr", 64'(imem_addr), 64'h10000B);
    chk("disc_req", 64'(imem_req), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 30'd0, 1'b0);
    chk("redir_addr", 64'(imem_addr), 64'h200);
    chk("redir_valid", 64'(inst_valid), 64'd0);
    chk("redir_inst", 64'(inst), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("discard_cnt1", 64'(discard_cnt), 64'd1);
`endif
    drive(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    chk("two_count", 64'(count), 64'd2);

    // redirect + ack + pop together with count=2
    drive(1'b1, 1'b1, 1'b1, 30'h3000, 1'b0);
    chk("rap_count", 64'(count), 64'd0);
    chk("rap_valid", 64'(inst_valid), 64'd0);
    chk("rap_addr", 64'(imem_addr), 64'h3000);
    chk("rap_req", 64'(imem_req), 64'd1);
    chk("rap_pc4", 64'(inst_pc_plus4), 64'd0);

    // PC wraps silently at the top of the 30-bit space
    drive(1'b1, 1'b0, 1'b1, 30'h3FFFFFFF, 1'b0);
    chk("wrap_start", 64'(imem_addr), 64'h3FFFFFFF);
    drive(1'b1, 1'b1, 1'b0, 30'd0, 1'b1);
    chk("wrap_addr", 64'(imem_addr), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 30'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 30'd0, 1'b1);
    chk("wrap_count", 64'(count), 64'd3);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", 64'(fetch_cnt), 64'd17);
    chk("discard_cnt3", 64'(discard_cnt), 64'd3);
`endif

    // one-cycle reset while a request is outstanding with count=3; ack ignored
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    inst_ready = 1'b0; redirect = 1'b0;
    tick();
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(inst_valid), 64'd0);
    chk("mid_rst_req", 64'(imem_req), 64'd0);
    chk("mid_rst_addr", 64'(imem_addr), 64'(RESET_PC));
`ifdef FETCH_PERF_CNT_EN
    chk("mid_rst_fcnt", 64'(fetch_cnt), 64'd0);
`endif
    sb.delete();
    pc_e = RESET_PC;
    reset = 1'b1; imem_ack = 1'b0;
    tick();
    chk("resume_addr", 64'(imem_addr), 64'(RESET_PC));
    repeat (3) drive(1'b1, 1'b1, 1'b0, 30'd0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 30'd0, 1'b0);
    chk("resume_count", 64'(count), 64'd0);
    chk("resume_sb", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
